// File: rtl/counter_bus_pkg.sv
// Shared register map, status codes and state encoding for the counter sequencer.
package counter_bus_pkg;
  localparam logic [1:0] ADDR_LOAD  = 2'd0;
  localparam logic [1:0] ADDR_LIMIT = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  localparam int CTRL_DIR = 0;
  localparam int CTRL_EN  = 1;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_DEVERR  = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_t;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_LOAD, S_WR_LIMIT, S_WR_CTRL, S_GAP, S_START,
    S_WAIT_EC, S_RD, S_CAP, S_RSP, S_WR_ABORT
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
  } bus_req_t;

  function automatic logic [7:0] ctrl_word(input logic en, input logic dir);
    ctrl_word           = '0;
    ctrl_word[CTRL_EN]  = en;
    ctrl_word[CTRL_DIR] = dir;
  endfunction
endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command/response channel plus counter bus pins; master = sequencer, slave = environment.
interface counter_seq_ctrl_if;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_load, cmd_limit;
  logic       cmd_dir;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_count;
  logic [1:0] rsp_status;
  logic       busy;
  logic       ncs, nwr, nrd;
  logic [1:0] a;
  logic [7:0] din;
  logic       start;
  logic [7:0] dout, count;
  logic       ec, err;

  modport master (
    input  cmd_valid, cmd_load, cmd_limit, cmd_dir, rsp_ready, dout, count, ec, err,
    output cmd_ready, rsp_valid, rsp_count, rsp_status, busy, ncs, nwr, nrd, a, din, start
  );
  modport slave (
    output cmd_valid, cmd_load, cmd_limit, cmd_dir, rsp_ready, dout, count, ec, err,
    input  cmd_ready, rsp_valid, rsp_count, rsp_status, busy, ncs, nwr, nrd, a, din, start
  );
endinterface

// File: rtl/ctr_bus_master.sv
// One registered bus access followed by one idle gap cycle; done is high during the gap.
module ctr_bus_master
  import counter_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  bus_req_t   req,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic [1:0] a,
  output logic [7:0] din,
  output logic       done
);
  typedef enum logic [1:0] {M_IDLE, M_ACC, M_GAP} phase_t;
  phase_t phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs   <= 1'b1;
      nwr   <= 1'b1;
      nrd   <= 1'b1;
      a     <= '0;
      din   <= '0;
      phase <= M_IDLE;
    end else if (go) begin
      ncs   <= 1'b0;
      nwr   <= ~req.wr;
      nrd   <= req.wr;
      a     <= req.a;
      din   <= req.d;
      phase <= M_ACC;
    end else if (phase == M_ACC) begin
      ncs   <= 1'b1;
      nwr   <= 1'b1;
      nrd   <= 1'b1;
      phase <= M_GAP;
    end else begin
      phase <= M_IDLE;
    end
  end

  assign done = (phase == M_GAP);
endmodule

// File: rtl/counter_seq_ctrl.sv
// Programs the counter, starts it, waits for end-of-count (or error/timeout) and reports.
module counter_seq_ctrl
  import counter_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  counter_seq_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t      state, gap_next;
  logic [7:0]  load_q, limit_q;
  logic        dir_q;
  logic [TW-1:0] tcnt;
  logic        start_q, rsp_valid_q;
  logic [7:0]  rsp_count_q;
  status_t     rsp_status_q;
  logic        go, done, timeout, abort;
  bus_req_t    req;

  assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign abort   = bus.err || (!bus.ec && timeout);

  // Requests are issued in the cycle before the access so the pins stay registered.
  always_comb begin
    go  = 1'b0;
    req = '{wr: 1'b1, a: ADDR_LOAD, d: 8'h00};
    case (state)
      S_IDLE: if (bus.cmd_valid) begin
        go  = 1'b1;
        req = '{wr: 1'b1, a: ADDR_LOAD, d: bus.cmd_load};
      end
      S_GAP: if (done && gap_next == S_WR_LIMIT) begin
        go  = 1'b1;
        req = '{wr: 1'b1, a: ADDR_LIMIT, d: limit_q};
      end else if (done && gap_next == S_WR_CTRL) begin
        go  = 1'b1;
        req = '{wr: 1'b1, a: ADDR_CTRL, d: ctrl_word(1'b1, dir_q)};
      end
      S_WAIT_EC: if (abort) begin
        go  = 1'b1;
        req = '{wr: 1'b1, a: ADDR_CTRL, d: 8'h00};
      end else if (bus.ec) begin
        go  = 1'b1;
        req = '{wr: 1'b0, a: ADDR_COUNT, d: 8'h00};
      end
      default: ;
    endcase
  end

  ctr_bus_master u_bus (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .req  (req),
    .ncs  (bus.ncs),
    .nwr  (bus.nwr),
    .nrd  (bus.nrd),
    .a    (bus.a),
    .din  (bus.din),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      gap_next     <= S_IDLE;
      load_q       <= '0;
      limit_q      <= '0;
      dir_q        <= 1'b0;
      tcnt         <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_count_q  <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          load_q  <= bus.cmd_load;
          limit_q <= bus.cmd_limit;
          dir_q   <= bus.cmd_dir;
          state   <= S_WR_LOAD;
        end
        S_WR_LOAD:  begin state <= S_GAP; gap_next <= S_WR_LIMIT; end
        S_WR_LIMIT: begin state <= S_GAP; gap_next <= S_WR_CTRL;  end
        S_WR_CTRL:  begin state <= S_GAP; gap_next <= S_START;    end
        S_WR_ABORT: begin state <= S_GAP; gap_next <= S_RSP;      end
        S_GAP: if (done) begin
          state <= gap_next;
          if (gap_next == S_START) start_q <= 1'b1;
          if (gap_next == S_RSP)   rsp_valid_q <= 1'b1;
        end
        S_START: begin
          tcnt  <= '0;
          state <= S_WAIT_EC;
        end
        S_WAIT_EC: begin
          if (bus.err) begin
            rsp_status_q <= ST_DEVERR;
            rsp_count_q  <= bus.count;
            state        <= S_WR_ABORT;
          end else if (bus.ec) begin
            rsp_status_q <= ST_OK;
            state        <= S_RD;
          end else if (timeout) begin
            rsp_status_q <= ST_TIMEOUT;
            rsp_count_q  <= bus.count;
            state        <= S_WR_ABORT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          rsp_count_q <= bus.dout;
          rsp_valid_q <= 1'b1;
          state       <= S_RSP;
        end
        S_RSP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = !rst && (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.start      = start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_count  = rsp_count_q;
  assign bus.rsp_status = rsp_status_q;
endmodule
